// File: rtl/uart_pkg.sv
// uart_pkg: UART state encodings and the baud divider, shared by uart_rx and uart_tx.
// Purely declarative: no logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud_rate);
    return clk_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous pin, 2 cycles of latency.
// No flow control; RST_VAL sets the level the pin is assumed to hold while in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic source_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge source_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling; rx_valid ~2+HALF_BIT+9*CLKS_PER_BIT cycles after the start edge.
// No backpressure: each byte is offered only for its single rx_valid cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_HZ    = 10_000_000
) (
  input  logic       source_clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_message,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_active
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic rx_s;

  uart_state_t      state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_index, bit_index_nxt;
  logic [7:0]       shift_reg, shift_reg_nxt;
  logic [7:0]       rx_message_nxt;
  logic             rx_valid_nxt, frame_err_nxt, rx_active_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .source_clk (source_clk),
    .rst_n      (rst_n),
    .d          (rx_serial),
    .q          (rx_s)
  );

  always_ff @(posedge source_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_index  <= '0;
      shift_reg  <= '0;
      rx_message <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_index  <= bit_index_nxt;
      shift_reg  <= shift_reg_nxt;
      rx_message <= rx_message_nxt;
      rx_valid   <= rx_valid_nxt;
      frame_err  <= frame_err_nxt;
      rx_active  <= rx_active_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    clk_cnt_nxt    = clk_cnt;
    bit_index_nxt  = bit_index;
    shift_reg_nxt  = shift_reg;
    rx_message_nxt = rx_message;
    rx_valid_nxt   = 1'b0;
    frame_err_nxt  = 1'b0;
    rx_active_nxt  = rx_active;

    unique case (state)
      ST_IDLE: begin
        clk_cnt_nxt   = '0;
        bit_index_nxt = '0;
        if (!rx_s) state_nxt = ST_START;
      end

      // A start that is high again by mid-bit was a glitch: drop it silently.
      ST_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt     = ST_DATA;
            rx_active_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt              = '0;
          shift_reg_nxt[bit_index] = rx_s;
          if (bit_index == 3'd7) begin
            bit_index_nxt = '0;
            state_nxt     = ST_STOP;
          end else begin
            bit_index_nxt = bit_index + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      // Decide at mid stop bit so a back-to-back start edge half a bit later is still caught.
      ST_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt   = '0;
          rx_active_nxt = 1'b0;
          state_nxt     = ST_CLEANUP;
          if (rx_s) begin
            rx_message_nxt = shift_reg;
            rx_valid_nxt   = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt     = ST_IDLE;
        clk_cnt_nxt   = '0;
        bit_index_nxt = '0;
        rx_active_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default-rate instance (1041 clk/bit) and a fast instance (10 clk/bit)
// driven from a bit-accurate serial model, checked against hand-computed expectations.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB_D = 1041;
  localparam int CPB_F = 10;

  logic       source_clk = 1'b0;
  logic       rst_n      = 1'b0;
  logic       rx_d       = 1'b1;
  logic       rx_f       = 1'b1;
  logic [7:0] msg_d, msg_f;
  logic       vld_d, err_d, act_d;
  logic       vld_f, err_f, act_f;

  uart_rx dut (
    .source_clk (source_clk),
    .rst_n      (rst_n),
    .rx_serial  (rx_d),
    .rx_message (msg_d),
    .rx_valid   (vld_d),
    .frame_err  (err_d),
    .rx_active  (act_d)
  );

  uart_rx #(.BAUD_RATE(100_000), .CLK_HZ(1_000_000)) dut_f (
    .source_clk (source_clk),
    .rst_n      (rst_n),
    .rx_serial  (rx_f),
    .rx_message (msg_f),
    .rx_valid   (vld_f),
    .frame_err  (err_f),
    .rx_active  (act_f)
  );

  always #5 source_clk = ~source_clk;

  int unsigned cyc = 0;
  always @(posedge source_clk) cyc++;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          nv_d = 0, ne_d = 0, nv_f = 0, ne_f = 0;
  int unsigned vcyc_d = 0;
  bit          both_hi = 1'b0;
  bit          act_seen_d = 1'b0;
  logic [7:0]  rxq_f[$];

  always @(negedge source_clk) begin
    if (vld_d) begin
      nv_d++;
      vcyc_d = cyc;
    end
    if (err_d) ne_d++;
    if (act_d) act_seen_d = 1'b1;
    if (vld_f) begin
      nv_f++;
      rxq_f.push_back(msg_f);
    end
    if (err_f) ne_f++;
    if ((vld_d && err_d) || (vld_f && err_f)) both_hi = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input bit fast, input logic v);
    if (fast) rx_f = v;
    else      rx_d = v;
  endtask

  // Full 8N1 frame, LSB first; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit fast);
    int cpb;
    cpb = fast ? CPB_F : CPB_D;
    drive(fast, 1'b0);
    repeat (cpb) @(negedge source_clk);
    for (int i = 0; i < 8; i++) begin
      drive(fast, d[i]);
      repeat (cpb) @(negedge source_clk);
    end
    drive(fast, stop);
    repeat (cpb) @(negedge source_clk);
  endtask

  typedef struct {
    logic [7:0] d;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_msg;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int nv0, ne0;
    int unsigned t0;

    tbl[0] = '{d: 8'h00, exp_v: 1, exp_e: 0, exp_msg: 8'h00};
    tbl[1] = '{d: 8'hFF, exp_v: 1, exp_e: 0, exp_msg: 8'hFF};
    tbl[2] = '{d: 8'h55, exp_v: 1, exp_e: 0, exp_msg: 8'h55};

    repeat (3) @(negedge source_clk);
    check("rst_msg",    int'(msg_d), 0);
    check("rst_valid",  int'(vld_d), 0);
    check("rst_ferr",   int'(err_d), 0);
    check("rst_active", int'(act_d), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge source_clk);

    // Single frame with latency measurement from the falling edge.
    nv0 = nv_d; ne0 = ne_d; t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_valid_cnt", nv_d - nv0, 1);
    check("a5_ferr_cnt",  ne_d - ne0, 0);
    check("a5_msg",       int'(msg_d), 8'hA5);
    n_cmp++;
    if ((vcyc_d - t0) < 9890 || (vcyc_d - t0) > 9892) begin
      n_bad++;
      $display("FAIL a5_latency: got %0d cycles, want 9891+/-1", vcyc_d - t0);
    end

    // Back-to-back frames, no idle gap.
    foreach (tbl[k]) begin
      nv0 = nv_d; ne0 = ne_d;
      send_frame(tbl[k].d, 1'b1, 1'b0);
      check($sformatf("b2b%0d_valid_cnt", k), nv_d - nv0, tbl[k].exp_v);
      check($sformatf("b2b%0d_ferr_cnt", k),  ne_d - ne0, tbl[k].exp_e);
      check($sformatf("b2b%0d_msg", k),       int'(msg_d), int'(tbl[k].exp_msg));
    end

    // Short low glitch on an idle line.
    repeat (2 * CPB_D) @(negedge source_clk);
    nv0 = nv_d; ne0 = ne_d; act_seen_d = 1'b0;
    rx_d = 1'b0;
    repeat (300) @(negedge source_clk);
    rx_d = 1'b1;
    repeat (1200) @(negedge source_clk);
    check("glitch_valid_cnt", nv_d - nv0, 0);
    check("glitch_ferr_cnt",  ne_d - ne0, 0);
    check("glitch_active",    int'(act_seen_d), 0);
    check("glitch_idle",      int'(dut.state), int'(ST_IDLE));
    check("glitch_msg_kept",  int'(msg_d), 8'h55);

    // Framing error followed by a 20 bit-time break, on the fast instance.
    repeat (50) @(negedge source_clk);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("pre_msg", int'(msg_f), 8'h5A);
    nv0 = nv_f; ne0 = ne_f;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20 * CPB_F) @(negedge source_clk);
    rx_f = 1'b1;
    repeat (3 * CPB_F) @(negedge source_clk);
    check("brk_ferr_cnt",  ne_f - ne0, 1);
    check("brk_valid_cnt", nv_f - nv0, 0);
    check("brk_msg_kept",  int'(msg_f), 8'h5A);
    send_frame(8'h81, 1'b1, 1'b1);
    check("post_brk_valid_cnt", nv_f - nv0, 1);
    check("post_brk_ferr_cnt",  ne_f - ne0, 1);
    check("post_brk_msg",       int'(msg_f), 8'h81);

    // Reset asserted in the middle of the data bits of 0xF0.
    repeat (2 * CPB_F) @(negedge source_clk);
    nv0 = nv_f; ne0 = ne_f;
    rx_f = 1'b0;
    repeat (4 * CPB_F + 5) @(negedge source_clk);
    check("mid_active", int'(act_f), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_msg",    int'(msg_f), 0);
    check("mid_rst_active", int'(act_f), 0);
    check("mid_rst_valid",  int'(vld_f), 0);
    @(negedge source_clk);
    rx_f = 1'b1;
    repeat (3) @(negedge source_clk);
    rst_n = 1'b1;
    repeat (4 * CPB_F) @(negedge source_clk);
    check("mid_rst_valid_cnt", nv_f - nv0, 0);
    check("mid_rst_ferr_cnt",  ne_f - ne0, 0);
    send_frame(8'h12, 1'b1, 1'b1);
    check("after_rst_valid_cnt", nv_f - nv0, 1);
    check("after_rst_msg",       int'(msg_f), 8'h12);

    // All 256 byte values back to back.
    repeat (2 * CPB_F) @(negedge source_clk);
    rxq_f.delete();
    ne0 = ne_f;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1'b1);
    repeat (2 * CPB_F) @(negedge source_clk);
    check("all_count", rxq_f.size(), 256);
    check("all_ferr",  ne_f - ne0, 0);
    for (int b = 0; b < 256; b++) begin
      if (b < rxq_f.size()) check($sformatf("all_byte%0d", b), int'(rxq_f[b]), b);
    end

    check("valid_and_ferr_together", int'(both_hi), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
